// File: rtl/stencil_stream_driver.sv
// Pixel stream source for a 1x2 linebuffer: a small FIFO feeds a registered
// in/wen pair, with raster position, frame flags and stencil-window qualification.
module stencil_stream_driver #(
  parameter int width = 16,
  parameter int img_w = 64,
  parameter int img_h = 64,
  parameter int depth = 4,
  localparam int xw = (img_w > 1) ? $clog2(img_w) : 1,
  localparam int yw = (img_h > 1) ? $clog2(img_h) : 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic [width-1:0] out_data,
  output logic             wen,
  output logic [xw-1:0]    x,
  output logic [yw-1:0]    y,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             stencil_valid
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [aw:0]   full_cnt = (aw+1)'(depth);
  localparam logic [aw-1:0] last_ptr = aw'(depth - 1);
  localparam logic [xw-1:0] last_x   = xw'(img_w - 1);
  localparam logic [yw-1:0] last_y   = yw'(img_h - 1);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr, rd_ptr;
  logic [aw:0]      count;
  logic [xw-1:0]    pos_x;
  logic [yw-1:0]    pos_y;
  logic             push, pop, last_col, last_row;

  // Upstream handshake: a pixel transfers on any rising edge where in_valid
  // and in_ready are both high; in_ready depends only on the registered count.
  assign in_ready = (count < full_cnt);
  assign push     = in_valid && in_ready;
  assign pop      = en && (count != '0);
  assign last_col = (pos_x == last_x);
  assign last_row = (pos_y == last_y);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // pos_x/pos_y name the position the next popped pixel will carry.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (pop) begin
      if (last_col) begin
        pos_x <= '0;
        pos_y <= last_row ? '0 : pos_y + 1'b1;
      end else begin
        pos_x <= pos_x + 1'b1;
      end
    end
  end

  // out_data, x and y hold on idle cycles so the linebuffer register keeps
  // the previous pixel of the row across gaps.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_data      <= '0;
      wen           <= 1'b0;
      x             <= '0;
      y             <= '0;
      sof           <= 1'b0;
      eol           <= 1'b0;
      eof           <= 1'b0;
      stencil_valid <= 1'b0;
    end else if (pop) begin
      out_data      <= mem[rd_ptr];
      wen           <= 1'b1;
      x             <= pos_x;
      y             <= pos_y;
      sof           <= (pos_x == '0) && (pos_y == '0);
      eol           <= last_col;
      eof           <= last_col && last_row;
      stencil_valid <= (pos_x != '0);
    end else begin
      wen           <= 1'b0;
      sof           <= 1'b0;
      eol           <= 1'b0;
      eof           <= 1'b0;
      stencil_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stencil_stream_driver.sv
// Scoreboard bench for stencil_stream_driver on a 4x2 frame with a 4-entry FIFO;
// expected pixels are derived from their raster index in the accepted stream.
module tb_stencil_stream_driver;

  localparam int W  = 16;
  localparam int IW = 4;
  localparam int IH = 2;
  localparam int D  = 4;
  localparam int XW = 2;
  localparam int YW = 1;

  logic          clk, arst_n;
  logic [W-1:0]  in_data;
  logic          in_valid, in_ready, en;
  logic [W-1:0]  out_data;
  logic          wen, sof, eol, eof, stencil_valid;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [W-1:0]  lb_reg;

  stencil_stream_driver #(.width(W), .img_w(IW), .img_h(IH), .depth(D)) dut (
    .clk(clk), .arst_n(arst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .en(en), .out_data(out_data), .wen(wen), .x(x), .y(y),
    .sof(sof), .eol(eol), .eof(eof), .stencil_valid(stencil_valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the linebuffer's internal register: samples in every clock
  always @(posedge clk) lb_reg <= out_data;

  typedef struct packed {
    logic          sv, eof, eol, sof;
    logic [YW-1:0] y;
    logic [XW-1:0] x;
    logic [W-1:0]  prev;
    logic [W-1:0]  data;
  } exp_t;

  exp_t     exp_q[$];
  int       errors = 0;
  int       checks = 0;
  int       model_k = 0;
  logic [W-1:0] model_last = '0;
  logic [W-1:0] last_out = '0;
  int       run_cur = 0;
  int       run_max = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // reference model: the k-th accepted pixel since reset sits at raster index k mod frame
  function automatic void model_push(input logic [W-1:0] d);
    exp_t e;
    int   col, row;
    col    = model_k % IW;
    row    = (model_k / IW) % IH;
    e.data = d;
    e.x    = XW'(col);
    e.y    = YW'(row);
    e.sof  = (col == 0) && (row == 0);
    e.eol  = (col == IW - 1);
    e.eof  = (col == IW - 1) && (row == IH - 1);
    e.sv   = (col != 0);
    e.prev = (col != 0) ? model_last : '0;
    exp_q.push_back(e);
    model_last = d;
    model_k    = (model_k + 1) % (IW * IH);
  endfunction

  // monitor: compares every wen cycle against the queue head, checks hold otherwise
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (arst_n) begin
        if (wen) begin
          run_cur++;
          if (run_cur > run_max) run_max = run_cur;
          if (exp_q.size() == 0) begin
            chk("unexpected_wen", {63'd0, wen}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 64'(out_data), 64'(e.data));
            chk("x", 64'(x), 64'(e.x));
            chk("y", 64'(y), 64'(e.y));
            chk("flags_sof_eol_eof_sv", 64'({sof, eol, eof, stencil_valid}),
                64'({e.sof, e.eol, e.eof, e.sv}));
            if (e.sv) chk("window_out_0_0", 64'(lb_reg), 64'(e.prev));
            last_out = e.data;
          end
        end else begin
          run_cur = 0;
          chk("hold_data", 64'(out_data), 64'(last_out));
          chk("idle_flags", 64'({sof, eol, eof, stencil_valid}), 64'd0);
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] d, input int vpct, input bit rnd_en);
    int t = 0;
    bit acc = 1'b0;
    while (!acc && t < 500) begin
      @(negedge clk);
      if (rnd_en) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(1, 100) <= vpct) begin
        in_valid = 1'b1;
        in_data  = d;
      end else begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
      end
      acc = in_valid && in_ready && arst_n;
      @(posedge clk);
      if (acc) model_push(d);
      t++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    en = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    arst_n   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_wen_flags", 64'({wen, sof, eol, eof, stencil_valid}), 64'd0);
    chk("rst_xy", 64'({x, y}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    model_k    = 0;
    model_last = '0;
    last_out   = '0;
    @(posedge clk);
    #2;
    arst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    int acc_n;
    int p;
    bit acc;
    arst_n   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    en       = 1'b1;
    #12;
    arst_n = 1'b1;

    // single pixel latency
    do_reset();
    en = 1'b1;
    send(16'h00AA, 100, 1'b0);
    idle();
    chk("latency_not_yet", 64'(wen), 64'd0);
    @(negedge clk);
    chk("latency_wen", 64'(wen), 64'd1);
    chk("latency_data", 64'(out_data), 64'h00AA);
    chk("latency_sof", 64'(sof), 64'd1);
    drain();

    // back-to-back full frame plus one: one pixel per cycle, wrap to sof
    do_reset();
    run_max = 0;
    for (int i = 1; i <= 9; i++) send(W'(i), 100, 1'b0);
    idle();
    drain();
    chk("wen_run_length", 64'(run_max), 64'd9);

    // en low: FIFO fills to depth, then drains in order
    do_reset();
    en    = 1'b0;
    acc_n = 0;
    p     = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = W'(16'h0100 + p);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        model_push(in_data);
        acc_n++;
        p++;
      end
    end
    @(negedge clk);
    chk("full_accepted", 64'(acc_n), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_wen", 64'(wen), 64'd0);
    en       = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_pop", 64'(in_ready), 64'd1);
    send(16'h0105, 100, 1'b0);
    send(16'h0106, 100, 1'b0);
    idle();
    drain();

    // random valid gaps and random en pauses across several frames
    do_reset();
    for (int i = 0; i < 40; i++) send(W'($urandom), 50, 1'b1);
    idle();
    drain();

    // reset mid-row with entries still queued
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) send(W'(16'h0200 + i), 100, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    en = 1'b0;
    send(16'h0300, 100, 1'b0);
    send(16'h0301, 100, 1'b0);
    idle();
    @(negedge clk);
    do_reset();
    en = 1'b1;
    send(16'h0055, 100, 1'b0);
    idle();
    @(negedge clk);
    chk("post_reset_data", 64'(out_data), 64'h0055);
    chk("post_reset_sof_x", 64'({sof, x}), 64'({1'b1, 2'b00}));
    drain();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
